// File: rtl/yasac_pkg.sv
// Shared encodings for the YASAC control unit: opcodes, ALU operations and FSM states.
package yasac_pkg;

  localparam int OP_STOP = 0;
  localparam int OP_LD   = 1;
  localparam int OP_ST   = 2;
  localparam int OP_MOV  = 3;
  localparam int OP_ADD  = 4;
  localparam int OP_SUB  = 5;
  localparam int OP_AND  = 6;
  localparam int OP_IN   = 7;
  localparam int OP_OUT  = 8;
  localparam int OP_JMP  = 9;
  localparam int OP_JZ   = 10;
  localparam int OP_JC   = 11;
  localparam int OP_NOP  = 12;
  localparam int OP_LAST = OP_NOP;

  typedef enum logic [2:0] {
    ALU_MOV = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/yasac_wait_timer.sv
// Memory wait watchdog: counts un-acknowledged request cycles, flags the last allowed one.
module yasac_wait_timer
  import yasac_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RESET || clear) cnt <= '0;
    else if (enable)     cnt <= cnt + CW'(1);
  end

  // High during the cycle whose increment would reach WAIT_MAX.
  assign expired = enable && (cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/yasac_control_unit.sv
// YASAC sequencer: fetch/decode/execute FSM driving PC, IR, memory and datapath strobes.
module yasac_control_unit
  import yasac_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int OPW      = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           START,
  input  logic [OPW-1:0] OPCODE,
  input  logic           ZF,
  input  logic           CF,
  input  logic           MEM_ACK,
  output logic           RDY,
  output logic           ERR,
  output logic           PC_CLR,
  output logic           PC_INC,
  output logic           PC_LD,
  output logic           IR_LD,
  output logic           MEM_REQ,
  output logic           MEM_WE,
  output logic [2:0]     ALU_OP,
  output logic           REG_WE,
  output logic           FLAG_WE,
  output logic           IO_RD,
  output logic           IO_WR
);

  state_e         state, nxt;
  logic [OPW-1:0] op_q;
  logic           err_q, err_set, err_clr;
  logic           mem_req, tmo;

  yasac_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (!mem_req || MEM_ACK),
    .enable  (mem_req && !MEM_ACK),
    .expired (tmo)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= S_IDLE;
      err_q <= 1'b0;
      op_q  <= '0;
    end else begin
      state <= nxt;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      // Capture the opcode so EXEC decodes from a stable register.
      if (state == S_DECODE) op_q <= OPCODE;
    end
  end

  always_comb begin
    nxt     = state;
    err_set = 1'b0;
    err_clr = 1'b0;
    RDY     = 1'b0;
    PC_CLR  = 1'b0;
    PC_INC  = 1'b0;
    PC_LD   = 1'b0;
    IR_LD   = 1'b0;
    mem_req = 1'b0;
    MEM_WE  = 1'b0;
    ALU_OP  = ALU_MOV;
    REG_WE  = 1'b0;
    FLAG_WE = 1'b0;
    IO_RD   = 1'b0;
    IO_WR   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        RDY = 1'b1;
        if (START) begin
          PC_CLR  = RESET;
          err_clr = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (MEM_ACK) begin
          IR_LD  = 1'b1;
          PC_INC = 1'b1;
          nxt    = S_DECODE;
        end else if (tmo) begin
          err_set = 1'b1;
          nxt     = S_DONE;
        end
      end
      S_DECODE: begin
        if (OPCODE == OPW'(OP_STOP)) begin
          nxt = S_DONE;
        end else if (OPCODE > OPW'(OP_LAST)) begin
          err_set = 1'b1;
          nxt     = S_DONE;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        nxt = S_FETCH;
        case (int'(op_q))
          OP_LD, OP_ST: begin
            mem_req = 1'b1;
            MEM_WE  = (int'(op_q) == OP_ST);
            if (MEM_ACK) begin
              REG_WE = (int'(op_q) == OP_LD);
            end else if (tmo) begin
              err_set = 1'b1;
              nxt     = S_DONE;
            end else begin
              nxt = S_EXEC;
            end
          end
          OP_MOV: begin ALU_OP = ALU_MOV; REG_WE = 1'b1; end
          OP_ADD: begin ALU_OP = ALU_ADD; REG_WE = 1'b1; FLAG_WE = 1'b1; end
          OP_SUB: begin ALU_OP = ALU_SUB; REG_WE = 1'b1; FLAG_WE = 1'b1; end
          OP_AND: begin ALU_OP = ALU_AND; REG_WE = 1'b1; FLAG_WE = 1'b1; end
          OP_IN:  begin IO_RD = 1'b1; REG_WE = 1'b1; end
          OP_OUT: IO_WR = 1'b1;
          OP_JMP: PC_LD = 1'b1;
          OP_JZ:  PC_LD = ZF;
          OP_JC:  PC_LD = CF;
          default: ;
        endcase
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign MEM_REQ = mem_req;
  assign ERR     = err_q;

endmodule
